// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// The NSA_SUB_EN build option is handled by the top, not here.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  function automatic int nibbles_of(input int width);
    return width / NIBBLE_W;
  endfunction

  // Nibble counter width; a single-nibble build still needs one bit.
  function automatic int cnt_width_of(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder, the single arithmetic element reused by the
// nibble-serial adder for every slice.
module ripple_carry_adder
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
    assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & w_carry[gi]) | (b[gi] & w_carry[gi]);
  end

  assign cout = w_carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that pushes one nibble per cycle (LSB first) through a single
// 4-bit ripple_carry_adder. Define NSA_SUB_EN to add the op_sub port (a-b).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = nibbles_of(WIDTH);
  localparam int CNT_W   = cnt_width_of(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
  end

  nsa_state_e          r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_carry;
  logic                r_cout;
  logic                r_out_valid;
  logic                r_in_ready;

  logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] w_rca_a;
  logic [NIBBLE_W-1:0] w_rca_b;
  logic [NIBBLE_W-1:0] w_rca_sum;
  logic                w_rca_cout;
  logic [WIDTH-1:0]    w_b_load;
  logic                w_carry_load;

  // Subtraction is a + ~b + 1, so it costs only an inverter and a forced carry.
`ifdef NSA_SUB_EN
  assign w_b_load     = op_sub ? ~b : b;
  assign w_carry_load = op_sub ? 1'b1 : cin;
`else
  assign w_b_load     = b;
  assign w_carry_load = cin;
`endif

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slice
    assign w_a_nib[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
  end

  assign w_rca_a = w_a_nib[r_cnt];
  assign w_rca_b = w_b_nib[r_cnt];

  ripple_carry_adder u_rca (
    .a    (w_rca_a),
    .b    (w_rca_b),
    .cin  (r_carry),
    .sum  (w_rca_sum),
    .cout (w_rca_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= w_b_load;
            r_carry    <= w_carry_load;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_rca_sum;
            end
          end
          r_carry <= w_rca_cout;
          // Counter wraps to 0 on the last nibble so it never exceeds NIBBLES-1.
          if (r_cnt == LAST_NIB) begin
            r_cnt       <= '0;
            r_cout      <= w_rca_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
